// File: rtl/updi_pkg.sv
// Shared UPDI definitions: UART TX state encoding, frame constants and parity helper.
package updi_pkg;

    localparam int unsigned UPDI_DATA_BITS = 8;
    localparam int unsigned UPDI_STOP_BITS = 2;
    localparam logic [7:0]  UPDI_SYNCH     = 8'h55;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } updi_uart_tx_state;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic updi_even_parity(input logic [UPDI_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/updi_baud_counter.sv
// Bit-time counter: counts 0..CLK_DIV-1 and ticks on the last count of each bit.
// Shared by the UPDI transmitter and the future UPDI receiver.
module updi_baud_counter #(
    parameter int unsigned CLK_DIV  = 16,
    parameter int unsigned DIV_BITS = $clog2(CLK_DIV)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    output logic [DIV_BITS-1:0] count,
    output logic                tick
);

    localparam logic [DIV_BITS-1:0] LAST = DIV_BITS'(CLK_DIV - 1);

    logic [DIV_BITS-1:0] count_q;
    logic [DIV_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q + DIV_BITS'(1);
        if (clear || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tick  = (count_q == LAST);

endmodule

// File: rtl/updi_uart_tx.sv
// UPDI UART transmitter: pops bytes from the instruction FIFO and sends 8E2 frames.
// Defining UPDI_UART_TX_BREAK_EN adds the send_break input and BREAK generation.
module updi_uart_tx #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned DIV_BITS   = $clog2(CLK_DIV),
    parameter int unsigned BREAK_BITS = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
`ifdef UPDI_UART_TX_BREAK_EN
    input  logic       send_break,
`endif
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       tx_en,
    output logic       busy,
    output logic       byte_done
);

    import updi_pkg::*;

    localparam logic [2:0] LAST_DATA_IDX = 3'(UPDI_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP_IDX = 3'(UPDI_STOP_BITS - 1);

    updi_uart_tx_state state_q, state_d;

    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                parity_q, parity_d;
    logic                frame_end_q, frame_end_d;

    logic                tx_q, tx_d;
    logic                tx_en_q, tx_en_d;
    logic                rd_en_q, rd_en_d;
    logic                busy_q, busy_d;
    logic                byte_done_q, byte_done_d;

    logic [DIV_BITS-1:0] baud_count;
    logic                baud_tick;
    logic                baud_clear;

`ifdef UPDI_UART_TX_BREAK_EN
    localparam int unsigned BRK_W = $clog2(BREAK_BITS + 1);

    logic [BRK_W-1:0]    brk_cnt_q, brk_cnt_d;
`else
    logic                unused_break_cfg;

    assign unused_break_cfg = |BREAK_BITS;
`endif

    // Counter restarts at 0 whenever the FSM changes state.
    assign baud_clear = (state_d != state_q);

    updi_baud_counter #(
        .CLK_DIV  (CLK_DIV),
        .DIV_BITS (DIV_BITS)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .count (baud_count),
        .tick  (baud_tick)
    );

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        frame_end_d = 1'b0;
`ifdef UPDI_UART_TX_BREAK_EN
        brk_cnt_d   = brk_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                bit_idx_d = '0;
`ifdef UPDI_UART_TX_BREAK_EN
                brk_cnt_d = '0;
                if (send_break) begin
                    state_d = BREAK;
                end else
`endif
                if (!fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = START;
            end
            START: begin
                // Pop data becomes valid one cycle after the visible rd_en, i.e. here.
                if (baud_count == '0) begin
                    shift_d  = fifo_data;
                    parity_d = updi_even_parity(fifo_data);
                end
                if (baud_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == LAST_DATA_IDX) begin
                        bit_idx_d = '0;
                        state_d   = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (bit_idx_q == LAST_STOP_IDX) begin
                        bit_idx_d   = '0;
                        frame_end_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UPDI_UART_TX_BREAK_EN
            BREAK: begin
                if (baud_tick) begin
                    if (brk_cnt_q == BRK_W'(BREAK_BITS)) begin
                        brk_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        brk_cnt_d = brk_cnt_q + BRK_W'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are a registered image of the current state, one cycle behind state_q.
    always_comb begin
        tx_d        = 1'b1;
        tx_en_d     = 1'b0;
        rd_en_d     = (state_q == IDLE) && (state_d == FETCH);
        busy_d      = (state_q != IDLE);
        byte_done_d = frame_end_q;
        case (state_q)
            START: begin
                tx_d    = 1'b0;
                tx_en_d = 1'b1;
            end
            DATA: begin
                tx_d    = shift_q[0];
                tx_en_d = 1'b1;
            end
            PARITY: begin
                tx_d    = parity_q;
                tx_en_d = 1'b1;
            end
            STOP: begin
                tx_en_d = 1'b1;
            end
`ifdef UPDI_UART_TX_BREAK_EN
            BREAK: begin
                tx_d    = (brk_cnt_q == BRK_W'(BREAK_BITS));
                tx_en_d = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            frame_end_q <= 1'b0;
`ifdef UPDI_UART_TX_BREAK_EN
            brk_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            frame_end_q <= frame_end_d;
`ifdef UPDI_UART_TX_BREAK_EN
            brk_cnt_q   <= brk_cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q        <= 1'b1;
            tx_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            tx_q        <= tx_d;
            tx_en_q     <= tx_en_d;
            rd_en_q     <= rd_en_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
        end
    end

    assign tx         = tx_q;
    assign tx_en      = tx_en_q;
    assign fifo_rd_en = rd_en_q;
    assign busy       = busy_q;
    assign byte_done  = byte_done_q;

endmodule

// File: tb/tb_updi_uart_tx.sv
// Self-checking bench for updi_uart_tx: table vectors, random bursts, reset and BREAK sequences.
module tb_updi_uart_tx;

    localparam int unsigned CD = 4;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       tx;
    logic       tx_en;
    logic       busy;
    logic       byte_done;
`ifdef UPDI_UART_TX_BREAK_EN
    logic       send_break;
`endif

    int errors = 0;
    int checks = 0;

    // FIFO model: writer owns mem/wr_ptr, reader owns rd_ptr/fifo_data.
    logic [7:0] mem [256];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pops = 0;
    int         pops_on_empty = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    updi_uart_tx #(
        .CLK_DIV    (CD),
        .BREAK_BITS (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
`ifdef UPDI_UART_TX_BREAK_EN
        .send_break (send_break),
`endif
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .tx_en      (tx_en),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            pops <= pops + 1;
            if (rd_ptr == wr_ptr) begin
                pops_on_empty <= pops_on_empty + 1;
            end else begin
                fifo_data <= mem[rd_ptr % 256];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 256] = b;
        wr_ptr++;
    endtask

    function automatic logic [4:0] obs();
        return {fifo_rd_en, busy, tx_en, tx, byte_done};
    endfunction

    // Compare {rd_en,busy,tx_en,tx,byte_done} at this falling edge, then advance one cycle.
    task automatic expect_cyc(input string name, input logic [4:0] exp);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got {rd,busy,en,tx,done}=%b exp=%b", name, $time, obs(), exp);
        end
        @(negedge clk);
    endtask

    // Expected line activity for back-to-back frames, starting at the first visible pop.
    task automatic check_frames(input logic [7:0] b[$], input logic p[$], input string name);
        int         n;
        logic [11:0] fr;
        n = 0;
        while (fifo_rd_en !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL %s_pop_timeout got rd_en=%b exp=1", name, fifo_rd_en);
            return;
        end
        for (int k = 0; k < b.size(); k++) begin
            fr[0] = 1'b0;
            for (int i = 0; i < 8; i++) fr[i+1] = b[k][i];
            fr[9]  = p[k];
            fr[10] = 1'b1;
            fr[11] = 1'b1;
            expect_cyc(name, {1'b1, 1'b0, 1'b0, 1'b1, (k > 0)});
            expect_cyc(name, 5'b01010);
            for (int i = 0; i < 12; i++) begin
                for (int c = 0; c < int'(CD); c++) begin
                    expect_cyc(name, {1'b0, 1'b1, 1'b1, fr[i], 1'b0});
                end
            end
        end
        expect_cyc(name, 5'b00011);
        expect_cyc(name, 5'b00010);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [8];
        logic [7:0] bq [$];
        logic       pq [$];
        logic [7:0] r;
        int         w;

        tbl[0] = '{updi_pkg::UPDI_SYNCH, 1'b0};
        tbl[1] = '{8'h07, 1'b1};
        tbl[2] = '{8'h00, 1'b0};
        tbl[3] = '{8'hC3, 1'b0};
        tbl[4] = '{8'h01, 1'b1};
        tbl[5] = '{8'hFF, 1'b0};
        tbl[6] = '{8'h80, 1'b1};
        tbl[7] = '{8'h3C, 1'b0};

        rst = 1'b1;
`ifdef UPDI_UART_TX_BREAK_EN
        send_break = 1'b0;
`endif
        repeat (3) @(negedge clk);
        expect_cyc("reset", 5'b00010);
        expect_cyc("reset", 5'b00010);
        rst = 1'b0;

        for (int i = 0; i < 200; i++) expect_cyc("idle_empty", 5'b00010);

        for (int i = 0; i < 8; i++) begin
            bq.delete();
            pq.delete();
            bq.push_back(tbl[i].data);
            pq.push_back(tbl[i].par);
            push(tbl[i].data);
            check_frames(bq, pq, $sformatf("vec%0d", i));
        end

        bq.delete();
        pq.delete();
        bq.push_back(8'h55); pq.push_back(1'b0);
        bq.push_back(8'hC3); pq.push_back(1'b0);
        bq.push_back(8'h01); pq.push_back(1'b1);
        push(8'h55);
        push(8'hC3);
        push(8'h01);
        check_frames(bq, pq, "burst3");

        bq.delete();
        pq.delete();
        for (int k = 0; k < 16; k++) begin
            r = 8'($urandom);
            bq.push_back(r);
            pq.push_back(($countones(r) % 2) == 1);
        end
        push(bq[0]);
        fork
            check_frames(bq, pq, "rand");
            begin
                for (int k = 1; k < bq.size(); k++) begin
                    w = 0;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!fifo_rd_en && w < 200);
                    repeat ($urandom_range(8 * CD, 1)) @(negedge clk);
                    push(bq[k]);
                end
            end
        join

        push(8'hA5);
        w = 0;
        while (!fifo_rd_en && w < 64) begin
            @(negedge clk);
            w++;
        end
        repeat (2 + CD * 4 + 1) @(negedge clk);
        checks++;
        if ({tx_en, tx} !== 2'b10) begin
            errors++;
            $display("FAIL mid_frame_bit3 got en,tx=%b exp=10", {tx_en, tx});
        end
        rst = 1'b1;
        @(negedge clk);
        expect_cyc("rst_mid", 5'b00010);
        expect_cyc("rst_mid", 5'b00010);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) expect_cyc("after_rst", 5'b00010);
        bq.delete();
        pq.delete();
        bq.push_back(8'h3C);
        pq.push_back(1'b0);
        push(8'h3C);
        check_frames(bq, pq, "post_rst");

`ifdef UPDI_UART_TX_BREAK_EN
        push(8'h5A);
        send_break = 1'b1;
        @(negedge clk);
        send_break = 1'b0;
        expect_cyc("brk_enter", 5'b00010);
        for (int i = 0; i < 48; i++) expect_cyc("brk_low", 5'b01100);
        for (int i = 0; i < 4; i++) expect_cyc("brk_high", 5'b01110);
        bq.delete();
        pq.delete();
        bq.push_back(8'h5A);
        pq.push_back(1'b0);
        fork
            check_frames(bq, pq, "brk_frame");
            begin
                repeat (20) @(negedge clk);
                send_break = 1'b1;
                @(negedge clk);
                send_break = 1'b0;
            end
        join
        for (int i = 0; i < 20; i++) expect_cyc("brk_not_queued", 5'b00010);
`endif

        checks++;
        if (pops_on_empty != 0) begin
            errors++;
            $display("FAIL pop_on_empty got %0d exp 0", pops_on_empty);
        end
        checks++;
        if (pops != wr_ptr) begin
            errors++;
            $display("FAIL pop_count got %0d exp %0d", pops, wr_ptr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/updi_uart_tx.md
Name: updi_uart_tx

Overview:
Downstream consumer of the byte FIFO filled by the UPDI instruction queue handler. It pops one byte at a time and serialises it onto the single-wire UPDI line as a UART frame: 1 start bit, 8 data bits LSB-first, even parity, 2 stop bits. It drives a separate output-enable so the half-duplex pad can be released between frames for the receive path.

Parameters:
- CLK_DIV, 16, clk cycles per bit time; minimum 2.
- DIV_BITS, $clog2(CLK_DIV), width of the baud counter.
- BREAK_BITS, 12, BREAK low duration in bit times (only used with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fifo_data  in  8  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  single-cycle FIFO pop.
- tx  out  1  line value; idle high.
- tx_en  out  1  pad drive enable; high only while a frame (or BREAK) is on the line.
- busy  out  1  high whenever state != IDLE.
- byte_done  out  1  one-cycle pulse after a frame's final stop bit.
- send_break  in  1  present only with UPDI_UART_TX_BREAK_EN.

Behaviour:
- Reset values: tx=1, tx_en=0, fifo_rd_en=0, busy=0, byte_done=0; state=IDLE; counters cleared.
- All outputs are registered.
- States and transitions:
  - IDLE: if !fifo_empty, assert fifo_rd_en for exactly one cycle and go to FETCH. Never assert fifo_rd_en while fifo_empty=1.
  - FETCH: latch fifo_data into the shift register. Compute parity = XOR of the 8 data bits, so the total count of ones across data and parity is even. Go to START.
  - START: tx=0, tx_en=1 for CLK_DIV cycles.
  - DATA: 8 bit times, bit0 first. Shift on each baud tick.
  - PARITY: 1 bit time.
  - STOP: tx=1 for 2 bit times. At the end, go to IDLE and pulse byte_done in the first IDLE cycle.
- Baud counter:
  - Counts 0..CLK_DIV-1.
  - Reloads at 0 on every state entry.
  - A bit ends when the counter reaches CLK_DIV-1.
  - Bit index counter is 3 bits and counts 0..7 in DATA; no wrap beyond 7.
- Frame length is exactly 12*CLK_DIV cycles from START entry to IDLE entry.
- Back-to-back bytes: the gap between the last stop-bit cycle and the next start bit is exactly 2 cycles (IDLE, FETCH). tx stays 1 during the gap; tx_en=0 during the gap.
- fifo_empty is sampled only in IDLE. Changes during a frame have no effect.
- Reset mid-frame: the next cycle shows reset values. The popped byte is discarded and no byte_done is generated.
- busy rises the cycle after fifo_rd_en and falls on IDLE entry.

Optional Feature:
UPDI_UART_TX_BREAK_EN
- Defined:
  - Adds the send_break input and a BREAK state.
  - In IDLE, send_break has priority over a non-empty FIFO.
  - BREAK drives tx=0, tx_en=1 for BREAK_BITS*CLK_DIV cycles, then tx=1, tx_en=1 for 1 bit time, then returns to IDLE.
  - No FIFO pop and no byte_done during BREAK.
  - send_break asserted outside IDLE is ignored; it is not queued.
- Undefined: no send_break port, no BREAK state; behaviour is otherwise identical.

Decomposition:
- Shared package updi_pkg:
  - updi_uart_tx_state enum: IDLE, FETCH, START, DATA, PARITY, STOP, BREAK.
  - Constants UPDI_DATA_BITS=8, UPDI_STOP_BITS=2, UPDI_SYNCH=8'h55.
- One natural sub-module: updi_baud_counter (CLK_DIV parameter; clear input; tick output at CLK_DIV-1). It is reusable by the future UPDI receiver.

Test Plan:
- CLK_DIV=4, FIFO holds 0x55 -> fifo_rd_en pulses once. tx shows 0,1,0,1,0,1,0,1,0,0,1,1 with each bit 4 cycles (48 cycles total, tx_en high throughout). byte_done pulses once.
- Byte 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1. Byte 0x00 -> parity 0.
- FIFO empty for 200 cycles -> fifo_rd_en never asserted, tx=1, tx_en=0, busy=0.
- FIFO preloaded with 0x55,0xC3,0x01 -> three frames in order, each gap exactly 2 cycles with tx=1/tx_en=0, three byte_done pulses.
- rst asserted during data bit 3 -> next cycle tx=1, tx_en=0, busy=0. No byte_done. After release, the next FIFO byte is sent normally.
- With UPDI_UART_TX_BREAK_EN, CLK_DIV=4: send_break while idle with FIFO non-empty -> tx=0 for 48 cycles, then tx=1 for 4 cycles with tx_en=1, then the FIFO byte frame follows.
